// File: rtl/uart_rx_oversample.sv
// UART receive engine (8N1 by default, LSB first) driven by a 16x oversample
// strobe. Recovers bytes from the asynchronous rx line and reports each one
// with a single-cycle data_valid pulse, or a framing_error pulse when the
// stop bit is sampled low.
//
// Output handshake: data_valid is a one-clk pulse with no back-pressure.
// data_out is updated in the same cycle that data_valid is high and holds its
// value until the next good frame. framing_error is a one-clk pulse that
// never coincides with data_valid and leaves data_out untouched.
module uart_rx_oversample #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 framing_error,
  output logic                 busy
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);

  // Mid-bit of the start bit, and the last tick of a full bit period.
  localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  // bit_cnt value at the sample that completes the data field.
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t               state;
  logic [TICK_W-1:0]    tick_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 rx_meta;
  logic                 rx_s;

  // Two-flop synchronizer for the asynchronous line; resets to idle-high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Frame FSM: counters advance only on baud_tick; output pulses self-clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      tick_cnt      <= '0;
      bit_cnt       <= '0;
      shift_reg     <= '0;
      data_out      <= '0;
      data_valid    <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      data_valid    <= 1'b0;
      framing_error <= 1'b0;
      if (baud_tick) begin
        case (state)
          IDLE: begin
            if (!rx_s) begin
              state    <= START;
              tick_cnt <= '0;
            end
          end
          START: begin
            if (tick_cnt == TICK_MID) begin
              if (!rx_s) begin
                // Start bit confirmed at its centre: align data sampling here.
                state    <= DATA;
                tick_cnt <= '0;
                bit_cnt  <= '0;
              end else begin
                // Line went back high before mid-bit: treat as a glitch.
                state    <= IDLE;
                tick_cnt <= '0;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          DATA: begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt  <= '0;
              // LSB arrives first, so shift in from the top.
              shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
              bit_cnt   <= bit_cnt + 1'b1;
              if (bit_cnt == BIT_LAST) begin
                state <= STOP;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          STOP: begin
            if (tick_cnt == TICK_LAST) begin
              // Leaving at mid-stop lets a back-to-back start edge be seen.
              tick_cnt <= '0;
              state    <= IDLE;
              if (rx_s) begin
                data_out   <= shift_reg;
                data_valid <= 1'b1;
              end else begin
                framing_error <= 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          default: begin
            state    <= IDLE;
            tick_cnt <= '0;
          end
        endcase
      end
    end
  end

  // Busy whenever a frame is in progress.
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Bench for uart_rx_oversample: OVERSAMPLE=16, baud_tick every 4 clk.
// Frames are timed in baud ticks so a paused baud_tick stretches the frame.
module tb_uart_rx_oversample;

  localparam int W = 9;  // {framing_error, data[7:0]}

  logic       clk;
  logic       rst;
  logic       baud_tick;
  logic       rx;
  logic [7:0] data_out;
  logic       data_valid;
  logic       framing_error;
  logic       busy;

  int tests = 0;
  int fails = 0;
  logic [W-1:0] exp_q[$];

  logic tick_en = 1'b1;
  int   tick_count = 0;
  int   tick_div = 0;

  uart_rx_oversample #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .baud_tick     (baud_tick),
    .rx            (rx),
    .data_out      (data_out),
    .data_valid    (data_valid),
    .framing_error (framing_error),
    .busy          (busy)
  );

  // Clock and baud strobe.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    baud_tick = 1'b0;
    forever begin
      @(negedge clk);
      tick_div = (tick_div + 1) % 4;
      if (tick_en && tick_div == 0) begin
        baud_tick = 1'b1;
        tick_count++;
      end else begin
        baud_tick = 1'b0;
      end
    end
  end

  // Watchdog.
  initial begin
    #2ms;
    $display("FAIL watchdog: sim still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Driver: hold rx at b for one bit period (16 baud ticks).
  task automatic send_bit(input logic b);
    int target;
    int guard;
    rx = b;
    target = tick_count + 16;
    guard = 0;
    while (tick_count < target && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 2000) begin
      fails++;
      tests++;
      $display("FAIL send_bit_timeout: got %0d ticks, expected %0d", tick_count, target);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop_bit);
  endtask

  task automatic drain(input string name);
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check({name, "_drain"}, exp_q.size(), 0);
  endtask

  // Monitor / scoreboard: pop on every output pulse.
  logic prev_pulse = 1'b0;
  always @(negedge clk) begin
    if (!rst && (data_valid || framing_error)) begin
      logic [W-1:0] exp;
      check("not_both", {data_valid, framing_error} == 2'b11, 0);
      check("pulse_width_one", prev_pulse, 0);
      check("busy_low_at_pulse", busy, 0);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pulse: got valid=%0b fe=%0b data=0x%0h, expected no pulse",
                 data_valid, framing_error, data_out);
      end else begin
        exp = exp_q.pop_front();
        check("pulse_kind_fe", framing_error, exp[8]);
        check("data_out", data_out, exp[7:0]);
      end
    end
    prev_pulse = data_valid || framing_error;
  end

  initial begin
    int busy_cnt;
    int busy_low;
    rx  = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("reset_data_out", data_out, 0);
    check("reset_valid", data_valid, 0);
    check("reset_fe", framing_error, 0);
    check("reset_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // Basic frame.
    exp_q.push_back({1'b0, 8'hA5});
    send_frame(8'hA5, 1'b1);
    drain("a5");
    send_bit(1'b1);

    // Good byte, then a framing error that must leave data_out alone.
    exp_q.push_back({1'b0, 8'h11});
    send_frame(8'h11, 1'b1);
    exp_q.push_back({1'b1, 8'h11});
    send_frame(8'h3C, 1'b0);
    rx = 1'b1;
    drain("fe");
    send_bit(1'b1);
    check("fe_data_out_kept", data_out, 8'h11);

    // Start-bit glitch: 4 ticks low.
    check("pre_glitch_busy", busy, 0);
    busy_cnt = 0;
    rx = 1'b0;
    repeat (16) begin
      @(negedge clk);
      if (busy) busy_cnt++;
    end
    rx = 1'b1;
    repeat (300) begin
      @(negedge clk);
      if (busy) busy_cnt++;
    end
    check("glitch_busy_seen", busy_cnt > 0, 1);
    check("glitch_busy_max", busy_cnt <= 36, 1);
    check("glitch_idle", busy, 0);
    check("glitch_q_empty", exp_q.size(), 0);

    // Back-to-back frames, no idle gap.
    exp_q.push_back({1'b0, 8'h00});
    exp_q.push_back({1'b0, 8'hFF});
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    drain("b2b");
    send_bit(1'b1);

    // Reset after 3 data bits of 0x5A.
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    rst = 1'b1;
    #1;
    check("midrst_data_out", data_out, 0);
    check("midrst_valid", data_valid, 0);
    check("midrst_fe", framing_error, 0);
    check("midrst_busy", busy, 0);
    rx = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    send_bit(1'b1);
    send_bit(1'b1);
    check("post_rst_q_empty", exp_q.size(), 0);
    exp_q.push_back({1'b0, 8'h81});
    send_frame(8'h81, 1'b1);
    drain("x81");
    send_bit(1'b1);

    // baud_tick paused for 200 clk mid-frame.
    busy_low = 0;
    exp_q.push_back({1'b0, 8'hC3});
    fork
      send_frame(8'hC3, 1'b1);
      begin
        repeat (300) @(negedge clk);
        tick_en = 1'b0;
        repeat (200) begin
          @(negedge clk);
          if (!busy) busy_low++;
        end
        tick_en = 1'b1;
      end
    join
    check("hold_busy_frozen", busy_low, 0);
    drain("c3");
    check("hold_data_out", data_out, 8'hC3);
    send_bit(1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
